// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and the instruction-buffer entry layout.
//   IB_ENTRY_W : width of one buffered entry ({pc, inst})
//   INST_W     : instruction width
//   PC_W       : program-counter width
//   ib_entry_t : packed entry, pc in the upper half, inst in the lower half
package cpu_pkg;

    localparam int unsigned INST_W     = 32;
    localparam int unsigned PC_W       = 32;
    localparam int unsigned IB_ENTRY_W = 64;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } ib_entry_t;

endpackage

// File: rtl/inst_buffer_mem.sv
// inst_buffer_mem: DEPTH x IB_ENTRY_W entry storage for the instruction buffer.
// One synchronous write port, one asynchronous read port, contents not reset.
// Ports:
//   clk   : rising-edge clock for the write port
//   we    : write enable
//   waddr : write address
//   wdata : entry to write
//   raddr : read address
//   rdata : entry at raddr (combinational)
module inst_buffer_mem
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [IB_ENTRY_W-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [IB_ENTRY_W-1:0] rdata
);

    logic [IB_ENTRY_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_buffer.sv
// inst_buffer: FIFO between fetch and decode holding {pc, inst} entries.
// Ports:
//   clk, reset                       : clock, asynchronous active-high reset
//   flush, excp_flush, ertn_flush    : any of these empties the buffer
//   inst_i, vaddr_i, ib_valid        : entry offered by fetch
//   ib_ready                         : buffer can accept an entry
//   id_inst, id_pc, id_valid         : head entry presented to decode
//   id_ready                         : decode consumes the head
// Configuration macro IB_BYPASS_EN: when defined, an offer into an empty
// buffer is presented to decode in the same cycle.
module inst_buffer
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              excp_flush,
    input  logic              ertn_flush,
    input  logic [INST_W-1:0] inst_i,
    input  logic [PC_W-1:0]   vaddr_i,
    input  logic              ib_valid,
    output logic              ib_ready,
    output logic [INST_W-1:0] id_inst,
    output logic [PC_W-1:0]   id_pc,
    output logic              id_valid,
    input  logic              id_ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    logic [AW:0]   count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          any_flush;
    logic          not_empty;
    logic          push;
    logic          pop;
    ib_entry_t     wr_entry;
    ib_entry_t     rd_entry;

    assign any_flush = flush | excp_flush | ertn_flush;
    assign not_empty = (count != '0);
    assign ib_ready  = (count != CNT_FULL);
    assign wr_entry  = '{pc: vaddr_i, inst: inst_i};

`ifdef IB_BYPASS_EN
    logic bypass;

    // Empty buffer: present the offered entry directly; if decode takes it,
    // it never enters storage.
    assign bypass   = !not_empty && ib_valid && !any_flush;
    assign id_valid = (not_empty && !any_flush) || bypass;
    assign id_inst  = bypass ? inst_i  : rd_entry.inst;
    assign id_pc    = bypass ? vaddr_i : rd_entry.pc;
    assign push     = ib_valid && ib_ready && !any_flush && !(bypass && id_ready);
    assign pop      = not_empty && id_valid && id_ready;
`else
    assign id_valid = not_empty && !any_flush;
    assign id_inst  = rd_entry.inst;
    assign id_pc    = rd_entry.pc;
    assign push     = ib_valid && ib_ready && !any_flush;
    assign pop      = id_valid && id_ready;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (any_flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    inst_buffer_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: self-checking bench for inst_buffer (DEPTH=4). A queue
// model of the FIFO predicts outputs every cycle; directed scenarios add
// literal expectations. Honours IB_BYPASS_EN like the design.
module tb_inst_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush, excp_flush, ertn_flush;
    logic [31:0] inst_i, vaddr_i;
    logic        ib_valid, ib_ready;
    logic [31:0] id_inst, id_pc;
    logic        id_valid, id_ready;

    int tests  = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;
    ent_t q[$];

    logic        obs_valid, obs_ready;
    logic [31:0] obs_pc, obs_inst;

    inst_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .excp_flush (excp_flush),
        .ertn_flush (ertn_flush),
        .inst_i     (inst_i),
        .vaddr_i    (vaddr_i),
        .ib_valid   (ib_valid),
        .ib_ready   (ib_ready),
        .id_inst    (id_inst),
        .id_pc      (id_pc),
        .id_valid   (id_valid),
        .id_ready   (id_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs (called at a negedge), compare against the
    // queue model, then let the rising edge happen and update the model.
    task automatic cycle(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic rdy, input logic fl, input logic ef, input logic ef2);
        logic anyfl, exp_ready, exp_valid, byp;
        logic [31:0] exp_pc, exp_inst;
        ib_valid = iv; vaddr_i = pc; inst_i = ins; id_ready = rdy;
        flush = fl; excp_flush = ef; ertn_flush = ef2;
        #1;
        anyfl     = fl | ef | ef2;
        exp_ready = (q.size() != DEPTH);
        exp_valid = (q.size() != 0) && !anyfl;
        exp_pc    = (q.size() != 0) ? q[0].pc   : 32'h0;
        exp_inst  = (q.size() != 0) ? q[0].inst : 32'h0;
        byp       = 1'b0;
`ifdef IB_BYPASS_EN
        if (q.size() == 0 && iv && !anyfl) begin
            byp = 1'b1; exp_valid = 1'b1; exp_pc = pc; exp_inst = ins;
        end
`endif
        obs_valid = id_valid; obs_ready = ib_ready; obs_pc = id_pc; obs_inst = id_inst;
        check("ib_ready", {31'b0, ib_ready}, {31'b0, exp_ready});
        check("id_valid", {31'b0, id_valid}, {31'b0, exp_valid});
        if (exp_valid) begin
            check("id_pc", id_pc, exp_pc);
            check("id_inst", id_inst, exp_inst);
        end
        @(posedge clk);
        if (anyfl) begin
            q.delete();
        end else begin
            if (exp_valid && rdy && q.size() != 0) void'(q.pop_front());
            if (iv && exp_ready && !(byp && rdy)) q.push_back('{pc: pc, inst: ins});
        end
        @(negedge clk);
    endtask

    task automatic idle_cycle(input logic rdy);
        cycle(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_cycle(input logic [31:0] pc, input logic rdy);
        cycle(1'b1, pc, pc ^ 32'h0280_0000, rdy, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; flush = 0; excp_flush = 0; ertn_flush = 0;
        inst_i = 0; vaddr_i = 0; ib_valid = 0; id_ready = 0;
        #2;
        check("reset ib_ready", {31'b0, ib_ready}, 32'd1);
        check("reset id_valid", {31'b0, id_valid}, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // Fill: 4 pushes with decode stalled, a 5th offer refused.
        for (int i = 0; i < 4; i++) push_cycle(32'h1c00_0000 + 32'(4 * i), 1'b0);
        push_cycle(32'h1c00_0010, 1'b0);
        check("fill ib_ready", {31'b0, obs_ready}, 32'd0);
        check("fill count", 32'(q.size()), 32'd4);

        // Drain order.
        for (int i = 0; i < 4; i++) begin
            idle_cycle(1'b1);
            check("drain pc", obs_pc, 32'h1c00_0000 + 32'(4 * i));
        end
        idle_cycle(1'b1);
        check("drain empty", {31'b0, obs_valid}, 32'd0);

        // Streaming at count=2, pointers wrap several times.
        push_cycle(32'h2000_0000, 1'b0);
        push_cycle(32'h2000_0004, 1'b0);
        for (int i = 0; i < 10; i++) begin
            push_cycle(32'h2000_0008 + 32'(4 * i), 1'b1);
            check("stream pc", obs_pc, 32'h2000_0000 + 32'(4 * i));
            check("stream ready", {31'b0, obs_ready}, 32'd1);
        end
        check("stream count", 32'(q.size()), 32'd2);
        idle_cycle(1'b1); idle_cycle(1'b1);

        // Flush collision with a push into count=3.
        for (int i = 0; i < 3; i++) push_cycle(32'h3000_0000 + 32'(4 * i), 1'b0);
        cycle(1'b1, 32'h3000_000c, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 1'b0);
        check("flush id_valid", {31'b0, obs_valid}, 32'd0);
        idle_cycle(1'b1);
        check("post flush empty", {31'b0, obs_valid}, 32'd0);
        check("post flush ready", {31'b0, obs_ready}, 32'd1);

        // Asynchronous reset mid-operation with count=2.
        push_cycle(32'h4000_0000, 1'b0);
        push_cycle(32'h4000_0004, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("async rst id_valid", {31'b0, id_valid}, 32'd0);
        check("async rst ib_ready", {31'b0, ib_ready}, 32'd1);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        push_cycle(32'h4000_0100, 1'b0);
        idle_cycle(1'b1);
        check("after rst pc", obs_pc, 32'h4000_0100);

        // Bypass / latency.
        cycle(1'b1, 32'h5000_0000, 32'h0280_0c21, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef IB_BYPASS_EN
        check("bypass valid", {31'b0, obs_valid}, 32'd1);
        check("bypass inst", obs_inst, 32'h0280_0c21);
        idle_cycle(1'b1);
        check("bypass count0", {31'b0, obs_valid}, 32'd0);
`else
        check("nobypass valid", {31'b0, obs_valid}, 32'd0);
        idle_cycle(1'b1);
        check("latency valid", {31'b0, obs_valid}, 32'd1);
        check("latency inst", obs_inst, 32'h0280_0c21);
`endif
        idle_cycle(1'b1);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), $urandom, $urandom, ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 31) == 0), ($urandom_range(0, 47) == 0),
                  ($urandom_range(0, 63) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    // Watchdog: a hang still reaches a verdict.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_buffer.md
INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of entries; a power of two, at least 2.
REQ-002 SHALL have port: clk  input  1  the single clock, rising-edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: flush / excp_flush / ertn_flush  input  1 each  pipeline redirect, exception, and ertn flushes.
REQ-005 SHALL have ports: inst_i  input  32, and vaddr_i  input  32  instruction and its PC from the fetch check stage.
REQ-006 SHALL have ports: ib_valid  input  1  fetch offers an entry; ib_ready  output  1  buffer accepts it.
REQ-007 SHALL have ports: id_inst  output  32, and id_pc  output  32  the head entry, presented to decode.
REQ-008 SHALL have ports: id_valid  output  1  head is valid; id_ready  input  1  decode consumes the head.

Function
REQ-009 SHALL push an entry {vaddr_i, inst_i} on every rising edge where ib_valid && ib_ready and no flush is asserted.
REQ-010 SHALL pop the head on every rising edge where id_valid && id_ready.
REQ-011 SHALL keep a count (0..DEPTH), a write pointer and a read pointer; both pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-012 SHALL drive ib_ready = (count != DEPTH); a full buffer refuses a push even if a pop happens in the same cycle.
REQ-013 SHALL drive id_valid = (count != 0) && !(flush|excp_flush|ertn_flush).
REQ-014 SHALL drive id_inst/id_pc from the entry at the read pointer; their value is don't-care while id_valid=0.
REQ-015 SHALL handle a simultaneous push and pop when 0<count<DEPTH by leaving count unchanged and advancing both pointers.
REQ-016 SHALL treat any flush as taking priority over push and pop: on the next edge count=0 and both pointers=0, and no entry is written.
REQ-017 SHALL keep held entries stable: id_inst/id_pc SHALL NOT change while id_valid=1 and id_ready=0.
REQ-018 SHALL, without bypass, have a latency of 1 cycle: an entry pushed at edge N appears with id_valid=1 after edge N.
REQ-019 SHALL keep the count change exactly one of +1, -1 or 0 per cycle; it never underflows or overflows.

Reset
REQ-020 SHALL, while reset=1, asynchronously set count=0, wr_ptr=0 and rd_ptr=0.
REQ-021 SHALL therefore drive ib_ready=1 and id_valid=0 during reset.
REQ-022 SHALL NOT reset entry storage contents.
REQ-023 SHALL, if reset is asserted mid-operation, discard all entries; the first edge after release accepts a push.

Configuration
REQ-024 SHALL use macro IB_BYPASS_EN to control empty-buffer bypass.
REQ-025 SHALL, with IB_BYPASS_EN defined:
- when count=0 and ib_valid=1 and no flush, drive id_valid=1 and id_inst/id_pc=inst_i/vaddr_i combinationally;
- if id_ready=1 that cycle, the entry is consumed and not written; otherwise it is written normally.
REQ-026 SHALL, without IB_BYPASS_EN, behave strictly per REQ-018 with no combinational path from ib_valid/inst_i to id_*.

Structure
REQ-027 SHALL place IB_ENTRY_W (64), INST_W (32), PC_W (32) and the entry struct typedef {pc, inst} in shared package cpu_pkg.
REQ-028 SHALL implement storage in one sub-module, inst_buffer_mem:
- DEPTH x IB_ENTRY_W;
- one synchronous write port;
- one asynchronous read port;
- no reset.
REQ-029 SHALL keep the control logic (count, pointers, flush, bypass) in inst_buffer.

Verification
REQ-030 SHALL cover fill: push 4 entries with pc 0x1c000000..0x1c00000c while id_ready=0 -> ib_ready=0 after the 4th; a 5th offer is not accepted.
REQ-031 SHALL cover drain order: with the buffer full, hold id_ready=1 for 4 cycles -> id_pc sequence 0x1c000000, 0x1c000004, 0x1c000008, 0x1c00000c, then id_valid=0.
REQ-032 SHALL cover streaming:
- hold ib_valid=1 and id_ready=1 continuously with count=2;
- count stays at 2;
- pointers wrap past 3 to 0 with no lost or duplicated pc.
REQ-033 SHALL cover flush collision: assert excp_flush in the same cycle as a push into count=3 -> id_valid=0 that cycle, count=0 next cycle, and the pushed entry is dropped.
REQ-034 SHALL cover reset mid-operation: assert reset asynchronously with count=2 -> id_valid=0 and ib_ready=1 immediately, before the next clk edge.
REQ-035 SHALL cover bypass: with IB_BYPASS_EN, empty buffer, ib_valid=1, inst_i=0x02800c21 and id_ready=1 -> id_inst=0x02800c21 the same cycle and count stays 0; without the macro, id_valid rises one cycle later.
